// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acq_pkg
//  Description : Shared types and constants for the acquisition sequencer:
//                the sequencer state encoding, default timeout constants
//                and the latched-configuration record.
//  Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

    // Default timing parameters for acq_sequencer.
    localparam int c_CNT_W_DEF         = 16;
    localparam int c_BUSY_TIMEOUT_DEF  = 64;
    localparam int c_FRAME_TIMEOUT_DEF = 500000;
    localparam int c_RESET_CYCLES_DEF  = 8;

    // Width of the numeric fields in the latched configuration record.
    // CNT_W of the sequencer must not exceed this value.
    localparam int c_CFG_W = 16;

    // Sequencer states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        ARM       = 3'd2,
        START     = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        GAP       = 3'd6,
        DONE      = 3'd7
    } acq_state_t;

    // Configuration captured on an accepted start; frames already has the
    // "0 means 1" substitution applied.
    typedef struct packed {
        logic               continuous;
        logic               dark_first;
        logic [c_CFG_W-1:0] frames;
        logic [c_CFG_W-1:0] int_time;
        logic [c_CFG_W-1:0] gap;
    } acq_cfg_t;

endpackage
`default_nettype wire

// File: rtl/acq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : acq_watchdog
//  Description : Loadable saturating up-counter with synchronous clear and
//                enable; o_tc is high while the count is at or above i_limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_watchdog #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count while enabled, sticking at all-ones so a long stall never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count >= i_limit);

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer
//  Description : Drives the timing generator through a multi-frame
//                acquisition: panel reset, optional dark frame, per-frame
//                start/integration, inter-frame gaps, abort handling and
//                busy/frame watchdogs.
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CNT_W         = c_CNT_W_DEF,
    parameter int BUSY_TIMEOUT  = c_BUSY_TIMEOUT_DEF,
    parameter int FRAME_TIMEOUT = c_FRAME_TIMEOUT_DEF,
    parameter int RESET_CYCLES  = c_RESET_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             cfg_continuous,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic             cfg_dark_first,
    input  logic [CNT_W-1:0] cfg_int_time,
    input  logic [CNT_W-1:0] cfg_gap,
    output logic             tg_frame_start,
    output logic             tg_frame_reset,
    output logic [CNT_W-1:0] tg_integration_time,
    input  logic             tg_frame_busy,
    input  logic             tg_frame_complete,
    output logic             seq_busy,
    output logic             seq_done,
    output logic [CNT_W-1:0] frames_done,
    output logic             dark_active,
    output logic             err_timeout
);

    localparam int c_WD_MAX = (FRAME_TIMEOUT > BUSY_TIMEOUT) ? FRAME_TIMEOUT : BUSY_TIMEOUT;
    localparam int c_WD_W   = $clog2(c_WD_MAX + 1);
    localparam int c_RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    acq_state_t         r_state;
    acq_cfg_t           r_cfg;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic               r_aborting;
    logic               r_busy_q;

    logic               w_frame_end;
    logic [CNT_W-1:0]   w_frames_inc;
    logic               w_target_hit;
    logic               w_wd_clear;
    logic               w_wd_en;
    logic [c_WD_W-1:0]  w_wd_limit;
    logic               w_wd_tc;

    // A completion pulse and a busy falling edge in the same cycle are one frame end.
    assign w_frame_end  = tg_frame_complete | (r_busy_q & ~tg_frame_busy);
    assign w_frames_inc = (frames_done == c_CNT_MAX) ? frames_done : frames_done + 1'b1;
    assign w_target_hit = ~r_cfg.continuous & ~dark_active &
                          (w_frames_inc >= CNT_W'(r_cfg.frames));

    // The watchdog starts from zero on the START cycle and again once busy is seen.
    assign w_wd_clear = (r_state == ARM) | ((r_state == WAIT_BUSY) & tg_frame_busy);
    assign w_wd_en    = (r_state == START) | (r_state == WAIT_BUSY) | (r_state == WAIT_DONE);
    assign w_wd_limit = (r_state == WAIT_DONE) ? c_WD_W'(FRAME_TIMEOUT) : c_WD_W'(BUSY_TIMEOUT);

    acq_watchdog #(
        .WIDTH (c_WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_wd_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_wd_en),
        .i_limit    (w_wd_limit),
        .o_tc       (w_wd_tc)
    );

    // Delayed busy, used to detect its falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= tg_frame_busy;
        end
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= IDLE;
            r_cfg               <= '0;
            r_rst_cnt           <= '0;
            r_gap_cnt           <= '0;
            r_aborting          <= 1'b0;
            tg_frame_start      <= 1'b0;
            tg_frame_reset      <= 1'b0;
            tg_integration_time <= '0;
            seq_busy            <= 1'b0;
            seq_done            <= 1'b0;
            frames_done         <= '0;
            dark_active         <= 1'b0;
            err_timeout         <= 1'b0;
        end else begin
            tg_frame_start <= 1'b0;
            seq_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_start) begin
                        r_cfg.continuous <= cfg_continuous;
                        r_cfg.dark_first <= cfg_dark_first;
                        r_cfg.frames     <= (cfg_frames == '0) ? c_CFG_W'(1) : c_CFG_W'(cfg_frames);
                        r_cfg.int_time   <= c_CFG_W'(cfg_int_time);
                        r_cfg.gap        <= c_CFG_W'(cfg_gap);
                        frames_done      <= '0;
                        err_timeout      <= 1'b0;
                        tg_frame_reset   <= 1'b1;
                        r_rst_cnt        <= '0;
                        r_aborting       <= 1'b0;
                        seq_busy         <= 1'b1;
                        r_state          <= RESET;
                    end
                end
                RESET: begin
                    // Also hosts the single-cycle panel reset issued on a mid-frame abort.
                    if (r_aborting || cmd_abort) begin
                        tg_frame_reset <= 1'b0;
                        seq_done       <= 1'b1;
                        r_state        <= DONE;
                    end else begin
                        if (r_rst_cnt == '0) begin
                            dark_active <= r_cfg.dark_first;
                        end
                        if (r_rst_cnt == c_RST_LAST) begin
                            tg_frame_reset      <= 1'b0;
                            tg_integration_time <= dark_active ? '0 : CNT_W'(r_cfg.int_time);
                            r_state             <= ARM;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (cmd_abort) begin
                        seq_done <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        tg_frame_start <= 1'b1;
                        r_state        <= START;
                    end
                end
                START: begin
                    if (cmd_abort) begin
                        tg_frame_reset <= 1'b1;
                        r_aborting     <= 1'b1;
                        r_state        <= RESET;
                    end else begin
                        r_state <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (cmd_abort) begin
                        tg_frame_reset <= 1'b1;
                        r_aborting     <= 1'b1;
                        r_state        <= RESET;
                    end else if (tg_frame_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (w_wd_tc) begin
                        err_timeout <= 1'b1;
                        seq_done    <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                WAIT_DONE: begin
                    // Abort outranks a coincident frame end, so that frame is not counted.
                    if (cmd_abort) begin
                        tg_frame_reset <= 1'b1;
                        r_aborting     <= 1'b1;
                        r_state        <= RESET;
                    end else if (w_frame_end) begin
                        if (dark_active) begin
                            dark_active <= 1'b0;
                        end else begin
                            frames_done <= w_frames_inc;
                        end
                        if (w_target_hit) begin
                            seq_done <= 1'b1;
                            r_state  <= DONE;
                        end else if (r_cfg.gap == '0) begin
                            tg_integration_time <= CNT_W'(r_cfg.int_time);
                            r_state             <= ARM;
                        end else begin
                            r_gap_cnt <= CNT_W'(1);
                            r_state   <= GAP;
                        end
                    end else if (w_wd_tc) begin
                        err_timeout <= 1'b1;
                        seq_done    <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                GAP: begin
                    if (cmd_abort) begin
                        seq_done <= 1'b1;
                        r_state  <= DONE;
                    end else if (r_gap_cnt == CNT_W'(r_cfg.gap)) begin
                        tg_integration_time <= CNT_W'(r_cfg.int_time);
                        r_state             <= ARM;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    dark_active <= 1'b0;
                    seq_busy    <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acq_sequencer
//  Description : Directed self-checking bench for acq_sequencer with a small
//                behavioural timing-generator responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_start;
    logic        cmd_abort;
    logic        cfg_continuous;
    logic [15:0] cfg_frames;
    logic        cfg_dark_first;
    logic [15:0] cfg_int_time;
    logic [15:0] cfg_gap;
    logic        tg_frame_start;
    logic        tg_frame_reset;
    logic [15:0] tg_integration_time;
    logic        tg_frame_busy;
    logic        tg_frame_complete;
    logic        seq_busy;
    logic        seq_done;
    logic [15:0] frames_done;
    logic        dark_active;
    logic        err_timeout;

    int tests_run = 0;
    int fails     = 0;

    // Responder / monitor state
    int          cyc = 0;
    int          n_start = 0;
    int          n_comp = 0;
    int          n_done = 0;
    int          n_frst = 0;
    int          err_cyc = -1;
    int          start_cyc [8];
    int          comp_cyc [8];
    int          frst_at_start [8];
    logic [15:0] int_at [8];
    logic        dark_at [8];
    logic        tg_respond = 1'b1;
    int          tg_busy_len = 50;
    logic        tg_run = 1'b0;
    int          tg_cnt = 0;

    acq_sequencer u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_start           (cmd_start),
        .cmd_abort           (cmd_abort),
        .cfg_continuous      (cfg_continuous),
        .cfg_frames          (cfg_frames),
        .cfg_dark_first      (cfg_dark_first),
        .cfg_int_time        (cfg_int_time),
        .cfg_gap             (cfg_gap),
        .tg_frame_start      (tg_frame_start),
        .tg_frame_reset      (tg_frame_reset),
        .tg_integration_time (tg_integration_time),
        .tg_frame_busy       (tg_frame_busy),
        .tg_frame_complete   (tg_frame_complete),
        .seq_busy            (seq_busy),
        .seq_done            (seq_done),
        .frames_done         (frames_done),
        .dark_active         (dark_active),
        .err_timeout         (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timing-generator model plus output monitor, both on the falling edge.
    // Busy rises 2 cycles after a start pulse, stays up tg_busy_len cycles,
    // and falls together with a completion pulse.
    initial begin
        tg_frame_busy     = 1'b0;
        tg_frame_complete = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tg_frame_start) begin
                if (n_start < 8) begin
                    start_cyc[n_start]     = cyc;
                    int_at[n_start]        = tg_integration_time;
                    dark_at[n_start]       = dark_active;
                    frst_at_start[n_start] = n_frst;
                end
                n_start++;
            end
            if (seq_done) n_done++;
            if (tg_frame_reset) n_frst++;
            if (err_timeout && (err_cyc < 0)) err_cyc = cyc;

            tg_frame_complete = 1'b0;
            if (rst || tg_frame_reset) begin
                tg_frame_busy = 1'b0;
                tg_run        = 1'b0;
            end else if (tg_run) begin
                tg_cnt++;
                if (tg_cnt == 2) begin
                    tg_frame_busy = 1'b1;
                end else if (tg_cnt == 2 + tg_busy_len) begin
                    tg_frame_busy     = 1'b0;
                    tg_frame_complete = 1'b1;
                    tg_run            = 1'b0;
                    if (n_comp < 8) comp_cyc[n_comp] = cyc;
                    n_comp++;
                end
            end else if (tg_frame_start && tg_respond) begin
                tg_run = 1'b1;
                tg_cnt = 0;
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        n_start = 0;
        n_comp  = 0;
        n_done  = 0;
        n_frst  = 0;
        err_cyc = -1;
    endtask

    task automatic start_acq(input logic cont, input logic [15:0] frames, input logic dark,
                             input logic [15:0] intt, input logic [15:0] gap);
        @(negedge clk);
        cfg_continuous = cont;
        cfg_frames     = frames;
        cfg_dark_first = dark;
        cfg_int_time   = intt;
        cfg_gap        = gap;
        cmd_start      = 1'b1;
        @(negedge clk);
        cmd_start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while ((seq_done !== 1'b1) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (seq_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_seq_done_timeout: waited %0d cycles, seq_done=%b expected 1", tag, k, seq_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tg_frame_start, tg_frame_reset, seq_busy, seq_done, dark_active, err_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {tg_frame_start, tg_frame_reset, seq_busy, seq_done, dark_active, err_timeout});
        end
        tests_run++;
        if (tg_integration_time !== 16'd0) begin
            fails++;
            $display("FAIL reset_int_time: got %0d expected 0", tg_integration_time);
        end
        tests_run++;
        if (frames_done !== 16'd0) begin
            fails++;
            $display("FAIL reset_frames_done: got %0d expected 0", frames_done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        clear_mon();
        tg_busy_len = 50;
        start_acq(1'b0, 16'd1, 1'b0, 16'd100, 16'd0);
        cfg_int_time = 16'd7;   // must not affect the running acquisition
        wait_done(2000, "single");
        tests_run++;
        if (n_start !== 1) begin
            fails++;
            $display("FAIL single_start_count: got %0d expected 1", n_start);
        end
        tests_run++;
        if (int_at[0] !== 16'd100) begin
            fails++;
            $display("FAIL single_int_time: got %0d expected 100", int_at[0]);
        end
        tests_run++;
        if (frst_at_start[0] !== 8) begin
            fails++;
            $display("FAIL single_reset_cycles: got %0d expected 8", frst_at_start[0]);
        end
        tests_run++;
        if (frames_done !== 16'd1) begin
            fails++;
            $display("FAIL single_frames_done: got %0d expected 1", frames_done);
        end
        tests_run++;
        if ((n_done !== 1) || (err_timeout !== 1'b0) || (seq_busy !== 1'b0)) begin
            fails++;
            $display("FAIL single_end_state: got done=%0d err=%b busy=%b expected 1 0 0", n_done, err_timeout, seq_busy);
        end
    endtask

    task automatic test_dark_first();
        clear_mon();
        start_acq(1'b0, 16'd2, 1'b1, 16'd40, 16'd3);
        wait_done(3000, "dark");
        tests_run++;
        if (n_start !== 3) begin
            fails++;
            $display("FAIL dark_start_count: got %0d expected 3", n_start);
        end
        tests_run++;
        if ((int_at[0] !== 16'd0) || (dark_at[0] !== 1'b1)) begin
            fails++;
            $display("FAIL dark_first_frame: got int=%0d dark=%b expected 0 1", int_at[0], dark_at[0]);
        end
        tests_run++;
        if ((int_at[1] !== 16'd40) || (dark_at[1] !== 1'b0) || (int_at[2] !== 16'd40)) begin
            fails++;
            $display("FAIL dark_light_frames: got int1=%0d dark1=%b int2=%0d expected 40 0 40",
                     int_at[1], dark_at[1], int_at[2]);
        end
        tests_run++;
        if (frames_done !== 16'd2) begin
            fails++;
            $display("FAIL dark_frames_done: got %0d expected 2", frames_done);
        end
    endtask

    task automatic test_gap();
        clear_mon();
        tg_busy_len = 10;
        start_acq(1'b0, 16'd3, 1'b0, 16'd10, 16'd20);
        wait_done(3000, "gap");
        // complete driven at cycle C -> 20 GAP cycles, ARM, then start seen at C+22
        tests_run++;
        if ((start_cyc[1] - comp_cyc[0]) !== 22) begin
            fails++;
            $display("FAIL gap_1: got %0d expected 22", start_cyc[1] - comp_cyc[0]);
        end
        tests_run++;
        if ((start_cyc[2] - comp_cyc[1]) !== 22) begin
            fails++;
            $display("FAIL gap_2: got %0d expected 22", start_cyc[2] - comp_cyc[1]);
        end
        tests_run++;
        if (frames_done !== 16'd3) begin
            fails++;
            $display("FAIL gap_frames_done: got %0d expected 3", frames_done);
        end
    endtask

    task automatic test_zero_frames();
        clear_mon();
        start_acq(1'b0, 16'd0, 1'b0, 16'd5, 16'd0);
        wait_done(2000, "zero");
        tests_run++;
        if ((n_start !== 1) || (frames_done !== 16'd1)) begin
            fails++;
            $display("FAIL zero_frames: got starts=%0d frames=%0d expected 1 1", n_start, frames_done);
        end
    endtask

    task automatic test_busy_timeout();
        clear_mon();
        tg_respond = 1'b0;
        start_acq(1'b0, 16'd1, 1'b0, 16'd9, 16'd0);
        wait_done(2000, "busy_to");
        tests_run++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL busy_to_err: got %b expected 1", err_timeout);
        end
        tests_run++;
        if ((err_cyc - start_cyc[0]) !== 65) begin
            fails++;
            $display("FAIL busy_to_latency: got %0d expected 65", err_cyc - start_cyc[0]);
        end
        tests_run++;
        if ((frames_done !== 16'd0) || (n_done !== 1)) begin
            fails++;
            $display("FAIL busy_to_end: got frames=%0d done=%0d expected 0 1", frames_done, n_done);
        end
        tg_respond = 1'b1;
        start_acq(1'b0, 16'd1, 1'b0, 16'd9, 16'd0);
        tests_run++;
        if ((err_timeout !== 1'b0) || (seq_busy !== 1'b1)) begin
            fails++;
            $display("FAIL busy_to_clear: got err=%b busy=%b expected 0 1", err_timeout, seq_busy);
        end
        wait_done(2000, "busy_to_rerun");
    endtask

    task automatic test_abort();
        int k;
        clear_mon();
        tg_busy_len = 30;
        start_acq(1'b1, 16'd1, 1'b0, 16'd5, 16'd2);
        k = 0;
        while (!((n_start >= 3) && (tg_frame_busy === 1'b1)) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (k >= 2000) begin
            fails++;
            $display("FAIL abort_reach_third_frame: got starts=%0d expected 3", n_start);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        n_frst = 0;
        n_done = 0;
        @(negedge clk);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        wait_done(100, "abort");
        tests_run++;
        if (n_frst !== 1) begin
            fails++;
            $display("FAIL abort_reset_pulse: got %0d cycles expected 1", n_frst);
        end
        tests_run++;
        if (frames_done !== 16'd2) begin
            fails++;
            $display("FAIL abort_frames_done: got %0d expected 2", frames_done);
        end
        tests_run++;
        if ((n_done !== 1) || (seq_busy !== 1'b0)) begin
            fails++;
            $display("FAIL abort_end: got done=%0d busy=%b expected 1 0", n_done, seq_busy);
        end
    endtask

    task automatic test_async_reset();
        int k;
        clear_mon();
        tg_busy_len = 40;
        start_acq(1'b0, 16'd2, 1'b0, 16'd10, 16'd0);
        k = 0;
        while (!((n_start >= 2) && (tg_frame_busy === 1'b1)) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({tg_frame_start, tg_frame_reset, seq_busy, seq_done, dark_active, err_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL async_flags: got %b expected 000000",
                     {tg_frame_start, tg_frame_reset, seq_busy, seq_done, dark_active, err_timeout});
        end
        tests_run++;
        if ((tg_integration_time !== 16'd0) || (frames_done !== 16'd0)) begin
            fails++;
            $display("FAIL async_values: got int=%0d frames=%0d expected 0 0", tg_integration_time, frames_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        start_acq(1'b0, 16'd1, 1'b0, 16'd12, 16'd0);
        wait_done(2000, "async_rerun");
        tests_run++;
        if ((frst_at_start[0] !== 8) || (int_at[0] !== 16'd12) || (frames_done !== 16'd1)) begin
            fails++;
            $display("FAIL async_rerun: got rst_cycles=%0d int=%0d frames=%0d expected 8 12 1",
                     frst_at_start[0], int_at[0], frames_done);
        end
    endtask

    initial begin
        rst            = 1'b1;
        cmd_start      = 1'b0;
        cmd_abort      = 1'b0;
        cfg_continuous = 1'b0;
        cfg_frames     = 16'd0;
        cfg_dark_first = 1'b0;
        cfg_int_time   = 16'd0;
        cfg_gap        = 16'd0;
        test_reset();
        test_single_frame();
        test_dark_first();
        test_gap();
        test_zero_frames();
        test_busy_timeout();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
